// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control token codes, lock-state encoding and the
// data-symbol decode helper used by the receive path.
package tmds_pkg;

    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

    typedef enum logic {
        LOCK_SEARCH = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_t;

    // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
    function automatic logic [7:0] tmds_decode_data(input logic [9:0] sym);
        logic [7:0] d;
        logic [7:0] px;
        d     = sym[9] ? ~sym[7:0] : sym[7:0];
        px[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            px[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return px;
    endfunction

endpackage

// File: rtl/tmds_lock_fsm.sv
// Word-alignment lock tracker: counts control-token runs to declare lock,
// requests a bitslip when no lock is found, and drops lock on token starvation.
module tmds_lock_fsm
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN   = 8,
    parameter int SEARCH_WIN = 4096,
    parameter int LOCK_WIN   = 4096
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sym_valid_i,
    input  logic       sym_is_ctrl_i,
    output logic       locked_o,
    output logic       bitslip_o,
    output logic [7:0] lock_loss_cnt_o
);

    localparam int RUN_W   = $clog2(CTRL_RUN + 1);
    localparam int WIN_MAX = (SEARCH_WIN > LOCK_WIN) ? SEARCH_WIN : LOCK_WIN;
    localparam int WIN_W   = $clog2(WIN_MAX + 1);

    lock_state_t      r_state;
    lock_state_t      w_state_next;
    logic [RUN_W-1:0] r_run;
    logic [RUN_W-1:0] w_run_next;
    logic [RUN_W-1:0] w_run_inc;
    logic [WIN_W-1:0] r_win;
    logic [WIN_W-1:0] w_win_next;
    logic [7:0]       r_loss;
    logic [7:0]       w_loss_next;
    logic             r_bitslip;
    logic             w_bitslip_next;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= LOCK_SEARCH;
            r_run     <= '0;
            r_win     <= '0;
            r_loss    <= '0;
            r_bitslip <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_run     <= w_run_next;
            r_win     <= w_win_next;
            r_loss    <= w_loss_next;
            r_bitslip <= w_bitslip_next;
        end
    end

    assign w_run_inc = (r_run == RUN_W'(CTRL_RUN)) ? r_run : r_run + 1'b1;

    always_comb begin
        w_state_next   = r_state;
        w_run_next     = r_run;
        w_win_next     = r_win;
        w_loss_next    = r_loss;
        w_bitslip_next = 1'b0;
        if (sym_valid_i) begin
            w_run_next = sym_is_ctrl_i ? w_run_inc : '0;
            case (r_state)
                LOCK_SEARCH: begin
                    // Completing the token run takes priority over window expiry.
                    if (sym_is_ctrl_i && (w_run_inc == RUN_W'(CTRL_RUN))) begin
                        w_state_next = LOCK_LOCKED;
                        w_win_next   = '0;
                    end else if (r_win == WIN_W'(SEARCH_WIN - 1)) begin
                        w_bitslip_next = 1'b1;
                        w_win_next     = '0;
                        w_run_next     = '0;
                    end else begin
                        w_win_next = r_win + 1'b1;
                    end
                end
                LOCK_LOCKED: begin
                    if (sym_is_ctrl_i) begin
                        w_win_next = '0;
                    end else if (r_win == WIN_W'(LOCK_WIN - 1)) begin
                        w_state_next = LOCK_SEARCH;
                        w_win_next   = '0;
                        w_run_next   = '0;
                        w_loss_next  = (r_loss == 8'hFF) ? r_loss : r_loss + 8'd1;
                    end else begin
                        w_win_next = r_win + 1'b1;
                    end
                end
                default: w_state_next = LOCK_SEARCH;
            endcase
        end
    end

    assign locked_o        = (r_state == LOCK_LOCKED);
    assign bitslip_o       = r_bitslip;
    assign lock_loss_cnt_o = r_loss;

endmodule

// File: rtl/tmds_dec.sv
// TMDS channel decoder: two-stage symbol pipeline (classify/decode, then output
// register) with a lock tracker fed from the stage-1 token detection.
module tmds_dec
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN   = 8,
    parameter int SEARCH_WIN = 4096,
    parameter int LOCK_WIN   = 4096
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] tmds_data_i,
    input  logic       tmds_data_valid_i,
    output logic [7:0] px_data_o,
    output logic       px_data_valid_o,
    output logic       h_sync_o,
    output logic       v_sync_o,
    output logic       sym_valid_o,
    output logic       locked_o,
    output logic       bitslip_o,
    output logic [7:0] lock_loss_cnt_o
);

    logic       w_is_ctrl;
    logic [1:0] w_ctrl;
    logic [7:0] w_px;

    logic       r_s1_valid;
    logic       r_s1_is_ctrl;
    logic [1:0] r_s1_ctrl;
    logic [7:0] r_s1_px;

    logic [7:0] r_px;
    logic       r_de;
    logic       r_h;
    logic       r_v;
    logic       r_sym_valid;

    always_comb begin
        w_is_ctrl = 1'b1;
        w_ctrl    = 2'b00;
        case (tmds_data_i)
            TMDS_CTRL_00: w_ctrl = 2'b00;
            TMDS_CTRL_01: w_ctrl = 2'b01;
            TMDS_CTRL_10: w_ctrl = 2'b10;
            TMDS_CTRL_11: w_ctrl = 2'b11;
            default:      w_is_ctrl = 1'b0;
        endcase
    end

    assign w_px = tmds_decode_data(tmds_data_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_valid   <= 1'b0;
            r_s1_is_ctrl <= 1'b0;
            r_s1_ctrl    <= '0;
            r_s1_px      <= '0;
        end else begin
            r_s1_valid   <= tmds_data_valid_i;
            r_s1_is_ctrl <= w_is_ctrl;
            r_s1_ctrl    <= w_ctrl;
            r_s1_px      <= w_px;
        end
    end

    // Empty slots still advance the pipe; pixel and sync values hold across them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_px        <= '0;
            r_de        <= 1'b0;
            r_h         <= 1'b0;
            r_v         <= 1'b0;
            r_sym_valid <= 1'b0;
        end else begin
            r_sym_valid <= r_s1_valid;
            r_de        <= r_s1_valid & ~r_s1_is_ctrl;
            if (r_s1_valid) begin
                if (r_s1_is_ctrl) begin
                    r_px <= 8'h00;
                    r_h  <= r_s1_ctrl[0];
                    r_v  <= r_s1_ctrl[1];
                end else begin
                    r_px <= r_s1_px;
                end
            end
        end
    end

    tmds_lock_fsm #(
        .CTRL_RUN  (CTRL_RUN),
        .SEARCH_WIN(SEARCH_WIN),
        .LOCK_WIN  (LOCK_WIN)
    ) u_lock_fsm (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .sym_valid_i    (r_s1_valid),
        .sym_is_ctrl_i  (r_s1_is_ctrl),
        .locked_o       (locked_o),
        .bitslip_o      (bitslip_o),
        .lock_loss_cnt_o(lock_loss_cnt_o)
    );

    assign px_data_o       = r_px;
    assign px_data_valid_o = r_de;
    assign h_sync_o        = r_h;
    assign v_sync_o        = r_v;
    assign sym_valid_o     = r_sym_valid;

endmodule

// File: tb/tb_tmds_dec.sv
// Directed bench for tmds_dec: vector table for decode/sync/strobe behaviour,
// encoder sweep, lock acquisition/loss, bitslip cadence and mid-stream reset.
module tb_tmds_dec;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [9:0] tmds_data_i = '0;
    logic       tmds_data_valid_i = 1'b0;
    logic [7:0] px_data_o;
    logic       px_data_valid_o;
    logic       h_sync_o;
    logic       v_sync_o;
    logic       sym_valid_o;
    logic       locked_o;
    logic       bitslip_o;
    logic [7:0] lock_loss_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    tmds_dec dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .tmds_data_i      (tmds_data_i),
        .tmds_data_valid_i(tmds_data_valid_i),
        .px_data_o        (px_data_o),
        .px_data_valid_o  (px_data_valid_o),
        .h_sync_o         (h_sync_o),
        .v_sync_o         (v_sync_o),
        .sym_valid_o      (sym_valid_o),
        .locked_o         (locked_o),
        .bitslip_o        (bitslip_o),
        .lock_loss_cnt_o  (lock_loss_cnt_o)
    );

    typedef struct {
        logic [9:0] sym;
        logic       vld;
        logic       sv;
        logic       de;
        logic [7:0] px;
        logic       h;
        logic       v;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic [9:0] sym, input logic vld, input logic sv,
                       input logic de, input logic [7:0] px, input logic h, input logic v);
        vec_t e;
        e.sym = sym; e.vld = vld; e.sv = sv; e.de = de; e.px = px; e.h = h; e.v = v;
        vt.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one symbol slot; outputs afterwards reflect the previous slot.
    task automatic cycle(input logic [9:0] s, input logic v);
        tmds_data_i       = s;
        tmds_data_valid_i = v;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i             = 1'b1;
        tmds_data_valid_i = 1'b0;
        tmds_data_i       = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".px"}, 32'(px_data_o), 0);
        chk({tag, ".de"}, 32'(px_data_valid_o), 0);
        chk({tag, ".hv"}, 32'({v_sync_o, h_sync_o}), 0);
        chk({tag, ".sv"}, 32'(sym_valid_o), 0);
        chk({tag, ".lock"}, 32'(locked_o), 0);
        chk({tag, ".slip"}, 32'(bitslip_o), 0);
        chk({tag, ".loss"}, 32'(lock_loss_cnt_o), 0);
    endtask

    // Reference DVI encoder with running disparity.
    function automatic logic [9:0] tmds_encode(input logic [7:0] d, inout int cnt);
        logic [8:0] qm;
        logic [9:0] q;
        int n1d, n1q, n0q;
        n1d   = $countones(d);
        qm[0] = d[0];
        if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (cnt == 0 || n1q == n0q) begin
            q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            if (qm[8] == 1'b0) cnt = cnt + n0q - n1q;
            else               cnt = cnt + n1q - n0q;
        end else if ((cnt > 0 && n1q > n0q) || (cnt < 0 && n0q > n1q)) begin
            q   = {1'b1, qm[8], ~qm[7:0]};
            cnt = cnt + (qm[8] ? 2 : 0) + n0q - n1q;
        end else begin
            q   = {1'b0, qm[8], qm[7:0]};
            cnt = cnt - (qm[8] ? 0 : 2) + n1q - n0q;
        end
        return q;
    endfunction

    initial begin
        int disp;
        int pulses;
        int first_k;
        int second_k;

        #1;
        chk_all_zero("rst0");
        do_reset();

        // sym, vld | sv de px h v   (expected once this slot reaches the output)
        add(10'h354, 1, 1, 0, 8'h00, 0, 0);
        add(10'h2AB, 1, 1, 0, 8'h00, 1, 1);
        add(10'h100, 1, 1, 1, 8'h00, 1, 1);
        add(10'h2FF, 1, 1, 1, 8'hFE, 1, 1);
        add(10'h0AB, 1, 1, 0, 8'h00, 1, 0);
        add(10'h1FF, 1, 1, 1, 8'h01, 1, 0);
        add(10'h1FF, 0, 0, 0, 8'h01, 1, 0);
        add(10'h154, 1, 1, 0, 8'h00, 0, 1);
        add(10'h2AB, 0, 0, 0, 8'h00, 0, 1);
        add(10'h0FF, 1, 1, 1, 8'hFF, 0, 1);
        add(10'h000, 0, 0, 0, 8'hFF, 0, 1);
        add(10'h155, 1, 1, 1, 8'hFF, 0, 1);
        add(10'h3AB, 1, 1, 1, 8'hFC, 0, 1);
        add(10'h0AB, 0, 0, 0, 8'hFC, 0, 1);
        add(10'h000, 1, 1, 1, 8'hFE, 0, 1);
        add(10'h354, 1, 1, 0, 8'h00, 0, 0);
        add(10'h2AB, 1, 1, 0, 8'h00, 1, 1);

        cycle(vt[0].sym, vt[0].vld);
        chk("vec.first_latency_sv", 32'(sym_valid_o), 0);
        for (int i = 0; i < vt.size(); i++) begin
            if (i + 1 < vt.size()) cycle(vt[i+1].sym, vt[i+1].vld);
            else                   cycle(10'h000, 1'b0);
            chk($sformatf("vec%0d.sv", i), 32'(sym_valid_o), 32'(vt[i].sv));
            chk($sformatf("vec%0d.de", i), 32'(px_data_valid_o), 32'(vt[i].de));
            chk($sformatf("vec%0d.px", i), 32'(px_data_o), 32'(vt[i].px));
            chk($sformatf("vec%0d.h", i), 32'(h_sync_o), 32'(vt[i].h));
            chk($sformatf("vec%0d.v", i), 32'(v_sync_o), 32'(vt[i].v));
            $display("vec %0d sym=%03h vld=%0d -> sv=%0d de=%0d px=%02h h=%0d v=%0d",
                     i, vt[i].sym, vt[i].vld, sym_valid_o, px_data_valid_o, px_data_o,
                     h_sync_o, v_sync_o);
        end

        // Encoder sweep: every byte must come back unchanged two cycles later.
        do_reset();
        disp = 0;
        for (int b = 0; b <= 256; b++) begin
            if (b < 256) cycle(tmds_encode(8'(b), disp), 1'b1);
            else         cycle(10'h000, 1'b0);
            if (b >= 1) begin
                chk($sformatf("enc%0d.px", b - 1), 32'(px_data_o), 32'(b - 1));
                chk($sformatf("enc%0d.de", b - 1), 32'(px_data_valid_o), 1);
            end
        end
        $display("encoder sweep 0x00..0xFF done");

        // Seven tokens then data: no lock.
        do_reset();
        for (int i = 0; i < 7; i++) cycle(10'h0AB, 1'b1);
        cycle(10'h100, 1'b1);
        cycle(10'h100, 1'b0);
        chk("run7.lock", 32'(locked_o), 0);
        $display("run of 7 tokens: locked=%0d", locked_o);

        // Eight tokens: lock appears with the eighth token's output.
        for (int i = 0; i < 8; i++) cycle(10'h0AB, 1'b1);
        chk("run8.lock_before", 32'(locked_o), 0);
        for (int j = 1; j <= 4096; j++) begin
            cycle(10'h100, 1'b1);
            if (j == 1) chk("run8.lock", 32'(locked_o), 1);
            if (j == 4096) begin
                chk("starve4095.lock", 32'(locked_o), 1);
                chk("starve4095.loss", 32'(lock_loss_cnt_o), 0);
            end
        end
        cycle(10'h100, 1'b1);
        chk("starve4096.lock", 32'(locked_o), 0);
        chk("starve4096.loss", 32'(lock_loss_cnt_o), 1);
        $display("lock loss: locked=%0d loss=%0d", locked_o, lock_loss_cnt_o);

        // Asynchronous reset mid-stream with symbols in flight.
        tmds_data_i       = 10'h2AB;
        tmds_data_valid_i = 1'b1;
        #2;
        rst_i = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(posedge clk_i);
        #1;
        chk_all_zero("midrst_hold");
        rst_i = 1'b0;
        cycle(10'h2AB, 1'b0);
        chk("post_rst.sv0", 32'(sym_valid_o), 0);
        cycle(10'h154, 1'b1);
        chk("post_rst.sv1", 32'(sym_valid_o), 0);
        cycle(10'h000, 1'b0);
        chk("post_rst.sv2", 32'(sym_valid_o), 1);
        chk("post_rst.hv", 32'({v_sync_o, h_sync_o}), 32'h2);
        cycle(10'h000, 1'b0);
        chk("post_rst.sv3", 32'(sym_valid_o), 0);
        $display("mid-stream reset: first symbol out after 2 cycles, hv=%0d%0d", v_sync_o, h_sync_o);

        // Bitslip cadence on a data-only stream.
        do_reset();
        pulses = 0; first_k = -1; second_k = -1;
        for (int k = 0; k <= 8192; k++) begin
            cycle(10'h100, 1'b1);
            if (bitslip_o) begin
                pulses++;
                if (first_k < 0) first_k = k;
                else if (second_k < 0) second_k = k;
            end
        end
        chk("slip.pulses", 32'(pulses), 2);
        chk("slip.first", 32'(first_k), 4096);
        chk("slip.second", 32'(second_k), 8192);
        $display("bitslip: pulses=%0d at %0d and %0d", pulses, first_k, second_k);

        // Run completes on the very symbol that would expire the window.
        do_reset();
        pulses = 0;
        for (int k = 0; k < 4088; k++) begin
            cycle(10'h100, 1'b1);
            if (bitslip_o) pulses++;
        end
        for (int k = 0; k < 8; k++) begin
            cycle(10'h0AB, 1'b1);
            if (bitslip_o) pulses++;
        end
        cycle(10'h000, 1'b0);
        if (bitslip_o) pulses++;
        cycle(10'h000, 1'b0);
        if (bitslip_o) pulses++;
        chk("tie.pulses", 32'(pulses), 0);
        chk("tie.lock", 32'(locked_o), 1);
        $display("lock/window tie: pulses=%0d locked=%0d", pulses, locked_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
